// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port priority helper for the register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 34;
  localparam int ADDR_W_DEF = 5;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // Turns the per-port address hits into a one-hot select in which port 1 beats port 0.
  // Both the storage write and the read bypass use it, so they always agree on the winner.
  function automatic logic [1:0] wr_match_sel(input logic hit0, input logic hit1);
    wr_match_sel = {hit1, hit0 & ~hit1};
  endfunction

endpackage

// File: rtl/regfile_scoreboard_mod.sv
// Per-register busy bits with set-over-clear priority, an incrementally kept
// busy count, and the busy lookup for every read port.
module regfile_scoreboard_mod
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W-1:0] wa0;
  logic [ADDR_W-1:0] wa1;
  logic              set_valid;
  logic              inc;
  logic              dec0;
  logic              dec1;
  logic [CNT_W-1:0]  cnt_q;

  // Next busy vector: writes clear first, then a valid set overrides a clear to the same register.
  // The count delta looks only at real transitions, so re-setting a busy register or clearing
  // an idle one leaves the count alone; port 1 is not counted twice when both ports hit one address.
  always_comb begin
    wa0       = wr_addr_i[0 +: ADDR_W];
    wa1       = wr_addr_i[ADDR_W +: ADDR_W];
    set_valid = busy_set_i && !((ZERO_REG != 0) && (busy_addr_i == '0));
    busy_d    = busy_q;
    if (wr_en_i[0]) busy_d[wa0] = 1'b0;
    if (wr_en_i[1]) busy_d[wa1] = 1'b0;
    if (set_valid)  busy_d[busy_addr_i] = 1'b1;
    inc  = set_valid && !busy_q[busy_addr_i];
    dec0 = wr_en_i[0] && busy_q[wa0] && !(set_valid && (wa0 == busy_addr_i));
    dec1 = wr_en_i[1] && busy_q[wa1] && !(set_valid && (wa1 == busy_addr_i))
           && !(wr_en_i[0] && (wa0 == wa1));
  end

  // Busy bits and the running count, both cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_q + {{(CNT_W-1){1'b0}}, inc}
                      - {{(CNT_W-1){1'b0}}, dec0}
                      - {{(CNT_W-1){1'b0}}, dec1};
    end
  end

  // Busy lookup per read port; a write completing this cycle hides the busy bit when bypassing.
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*ADDR_W +: ADDR_W]]
        && !((BYPASS != 0)
             && ((wr_en_i[0] && (wa0 == rd_addr_i[k*ADDR_W +: ADDR_W]))
              || (wr_en_i[1] && (wa1 == rd_addr_i[k*ADDR_W +: ADDR_W]))));
    end
  end

  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_mod.sv
// Multi-port register file: storage with two prioritised write ports, combinational
// reads with optional write bypass and zero register, plus the busy scoreboard.
module regfile_mp_mod
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [1:0]               wr_en_i,
  input  logic [2*ADDR_W-1:0]      wr_addr_i,
  input  logic [2*DATA_W-1:0]      wr_data_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [1:0]        wr_eff;
  logic [1:0]        wr_sel  [DEPTH];
  logic [1:0]        byp_sel [NUM_RD];

  // Effective write enables: with a zero register, writes to address 0 vanish entirely.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wr_eff[k] = wr_en_i[k]
        && !((ZERO_REG != 0) && (wr_addr_i[k*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Per-register write select, port 1 taking the register when both ports target it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = wr_match_sel(wr_eff[0] && (wr_addr_i[0 +: ADDR_W] == ADDR_W'(i)),
                               wr_eff[1] && (wr_addr_i[ADDR_W +: ADDR_W] == ADDR_W'(i)));
    end
  end

  // Storage array; reset clears every register and drops any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i][1])      regs_q[i] <= wr_data_i[DATA_W +: DATA_W];
        else if (wr_sel[i][0]) regs_q[i] <= wr_data_i[0 +: DATA_W];
      end
    end
  end

  // Read ports: stored value, overridden by a same-cycle write when bypassing, zero for register 0.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      byp_sel[k] = wr_match_sel(
        wr_eff[0] && (wr_addr_i[0 +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W]),
        wr_eff[1] && (wr_addr_i[ADDR_W +: ADDR_W] == rd_addr_i[k*ADDR_W +: ADDR_W]));
      rd_data_o[k*DATA_W +: DATA_W] = regs_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
      if (BYPASS != 0) begin
        if (byp_sel[k][1])      rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[DATA_W +: DATA_W];
        else if (byp_sel[k][0]) rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[0 +: DATA_W];
      end
      if ((ZERO_REG != 0) && (rd_addr_i[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_data_o[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regfile_scoreboard_mod #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr_i),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .busy_set_i (busy_set_i),
    .busy_addr_i(busy_addr_i),
    .busy_cnt_o (busy_cnt_o)
  );

endmodule
